// File: rtl/compare_seq_ctrl.sv
// Sequencer for a shared bit-serial comparator: accepts an operand pair, clears the
// comparator, streams both operands LSB-first, then captures and returns g/e.
module compare_seq_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_y,
  output logic         cmp_clr,
  output logic         cmp_x,
  output logic         cmp_y,
  input  logic         cmp_g,
  input  logic         cmp_e,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_g,
  output logic         out_e,
  output logic         busy
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     sx_q, sx_d;
  logic [N-1:0]     sy_q, sy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_g_q, out_g_d;
  logic             out_e_q, out_e_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, neither depends on inputs.
  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    cnt_d   = cnt_q;
    out_g_d = out_g_q;
    out_e_d = out_e_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sx_d    = in_x;
          sy_d    = in_y;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        sx_d  = sx_q >> 1;
        sy_d  = sy_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        out_g_d = cmp_g;
        out_e_d = cmp_e;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      cnt_q   <= '0;
      out_g_q <= 1'b0;
      out_e_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cnt_q   <= cnt_d;
      out_g_q <= out_g_d;
      out_e_q <= out_e_d;
    end
  end

  // Comparator-facing outputs decode registered state only.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign cmp_clr   = (state_q == CLEAR);
  assign cmp_x     = (state_q == SHIFT) & sx_q[0];
  assign cmp_y     = (state_q == SHIFT) & sy_q[0];
  assign out_valid = (state_q == DONE);
  assign out_g     = out_g_q;
  assign out_e     = out_e_q;

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Bench for compare_seq_ctrl: three instances (N=8 directed, N=32 and N=1 random) each
// attached to a behavioural serial comparator; results checked against x>y / x==y.
module tb_compare_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  localparam int NB [3] = '{8, 32, 1};

  logic        in_valid_a  [3] = '{default: 1'b0};
  logic        out_ready_a [3] = '{default: 1'b0};
  logic [31:0] in_x_a      [3] = '{default: '0};
  logic [31:0] in_y_a      [3] = '{default: '0};
  logic        cmp_g_a     [3] = '{default: 1'b0};
  logic        cmp_e_a     [3] = '{default: 1'b1};
  logic in_ready_a [3];
  logic cmp_clr_a  [3];
  logic cmp_x_a    [3];
  logic cmp_y_a    [3];
  logic out_valid_a[3];
  logic out_g_a    [3];
  logic out_e_a    [3];
  logic busy_a     [3];

  compare_seq_ctrl #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_x(in_x_a[0][7:0]), .in_y(in_y_a[0][7:0]), .cmp_clr(cmp_clr_a[0]),
    .cmp_x(cmp_x_a[0]), .cmp_y(cmp_y_a[0]), .cmp_g(cmp_g_a[0]), .cmp_e(cmp_e_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_g(out_g_a[0]),
    .out_e(out_e_a[0]), .busy(busy_a[0])
  );

  compare_seq_ctrl #(.N(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_x(in_x_a[1]), .in_y(in_y_a[1]), .cmp_clr(cmp_clr_a[1]),
    .cmp_x(cmp_x_a[1]), .cmp_y(cmp_y_a[1]), .cmp_g(cmp_g_a[1]), .cmp_e(cmp_e_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_g(out_g_a[1]),
    .out_e(out_e_a[1]), .busy(busy_a[1])
  );

  compare_seq_ctrl #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_x(in_x_a[2][0:0]), .in_y(in_y_a[2][0:0]), .cmp_clr(cmp_clr_a[2]),
    .cmp_x(cmp_x_a[2]), .cmp_y(cmp_y_a[2]), .cmp_g(cmp_g_a[2]), .cmp_e(cmp_e_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_g(out_g_a[2]),
    .out_e(out_e_a[2]), .busy(busy_a[2])
  );

  // Serial comparator: bits arrive LSB first, so the latest differing bit decides g.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cmp_clr_a[k]) begin
        cmp_g_a[k] <= 1'b0;
        cmp_e_a[k] <= 1'b1;
      end else if (cmp_x_a[k] != cmp_y_a[k]) begin
        cmp_g_a[k] <= cmp_x_a[k];
        cmp_e_a[k] <= 1'b0;
      end
    end
  end

  int clr_cnt [3] = '{default: 0};
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (cmp_clr_a[k]) clr_cnt[k] <= clr_cnt[k] + 1;
  end

  int errors = 0;
  int checks = 0;
  int ops_acc [3] = '{default: 0};
  logic last_g [3] = '{default: 1'b0};
  logic last_e [3] = '{default: 1'b0};
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask_of(input int k);
    return (NB[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << NB[k]) - 32'h1);
  endfunction

  task automatic check_idle(input int k, input string tag);
    check({tag, "_in_ready"}, in_ready_a[k], 1);
    check({tag, "_out_valid"}, out_valid_a[k], 0);
    check({tag, "_busy"}, busy_a[k], 0);
    check({tag, "_cmp"}, {cmp_clr_a[k], cmp_x_a[k], cmp_y_a[k]}, 0);
  endtask

  // Presents the pair and waits (bounded) for the accepting edge.
  task automatic do_accept(input int k, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] m, xm, ym;
    int waited;
    m  = mask_of(k);
    xm = x & m;
    ym = y & m;
    in_valid_a[k] = 1'b1;
    in_x_a[k] = x;
    in_y_a[k] = y;
    waited = 0;
    while (!in_ready_a[k] && waited < 100) begin
      step();
      waited++;
    end
    check("accept_wait", in_ready_a[k], 1);
    step();
    ops_acc[k]++;
    exp_q.push_back({xm > ym, xm == ym});
    in_valid_a[k] = 1'b0;
    in_x_a[k] = $urandom;
    in_y_a[k] = $urandom;
    check("accept_busy", busy_a[k], 1);
    check("accept_in_ready", in_ready_a[k], 0);
  endtask

  // From the CLEAR cycle to the first DONE cycle: clear pulse, N serial bits, capture.
  task automatic do_body(input int k, input logic [31:0] x, input logic [31:0] y);
    logic [1:0] exp;
    check("clear_pulse", cmp_clr_a[k], 1);
    check("clear_bits", {cmp_x_a[k], cmp_y_a[k]}, 0);
    check("clear_out_valid", out_valid_a[k], 0);
    for (int i = 0; i < NB[k]; i++) begin
      out_ready_a[k] = 1'($urandom_range(0, 1));
      step();
      check("shift_clr", cmp_clr_a[k], 0);
      check("shift_x", cmp_x_a[k], x[i]);
      check("shift_y", cmp_y_a[k], y[i]);
      check("shift_out_valid", out_valid_a[k], 0);
      check("shift_out_hold", {out_g_a[k], out_e_a[k]}, {last_g[k], last_e[k]});
    end
    out_ready_a[k] = 1'($urandom_range(0, 1));
    step();
    check("capture_bits", {cmp_clr_a[k], cmp_x_a[k], cmp_y_a[k]}, 0);
    check("capture_out_valid", out_valid_a[k], 0);
    check("capture_busy", busy_a[k], 1);
    step();
    exp = exp_q.pop_front();
    check("done_out_valid", out_valid_a[k], 1);
    check("done_out_g", out_g_a[k], exp[1]);
    check("done_out_e", out_e_a[k], exp[0]);
    check("done_in_ready", in_ready_a[k], 0);
    last_g[k] = exp[1];
    last_e[k] = exp[0];
  endtask

  task automatic drain(input int k);
    logic r;
    for (int j = 0; j < 40; j++) begin
      r = ($urandom_range(0, 2) == 0) || (j == 39);
      out_ready_a[k] = r;
      step();
      if (r) begin
        check("drain_out_valid", out_valid_a[k], 0);
        check("drain_in_ready", in_ready_a[k], 1);
        check("drain_hold", {out_g_a[k], out_e_a[k]}, {last_g[k], last_e[k]});
        break;
      end
      check("stall_out_valid", out_valid_a[k], 1);
      check("stall_hold", {out_g_a[k], out_e_a[k]}, {last_g[k], last_e[k]});
    end
    out_ready_a[k] = 1'b0;
  endtask

  task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] y);
    do_accept(k, x, y);
    do_body(k, x, y);
    drain(k);
  endtask

  logic [31:0] rx, ry;

  initial begin
    // Reset
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      check_idle(k, "reset");
      check("reset_out", {out_g_a[k], out_e_a[k]}, 0);
    end
    rst = 1'b1;
    step();
    for (int k = 0; k < 3; k++) check_idle(k, "post_reset");

    // Directed results at N=8
    run_op(0, 32'h5A, 32'h3C);
    run_op(0, 32'hA5, 32'hA5);
    run_op(0, 32'h01, 32'h80);
    run_op(0, 32'hFF, 32'hFE);
    check("dir_last_g", out_g_a[0], 1);
    check("dir_last_e", out_e_a[0], 0);

    // Backpressure with a pending request held during DONE
    do_accept(0, 32'h33, 32'h44);
    do_body(0, 32'h33, 32'h44);
    in_valid_a[0] = 1'b1;
    in_x_a[0] = 32'h77;
    in_y_a[0] = 32'h77;
    out_ready_a[0] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step();
      check("bp_out_valid", out_valid_a[0], 1);
      check("bp_hold", {out_g_a[0], out_e_a[0]}, {last_g[0], last_e[0]});
      check("bp_in_ready", in_ready_a[0], 0);
    end
    out_ready_a[0] = 1'b1;
    step();
    out_ready_a[0] = 1'b0;
    check("bp_release_in_ready", in_ready_a[0], 1);
    check("bp_release_out_valid", out_valid_a[0], 0);
    do_accept(0, 32'h77, 32'h77);
    do_body(0, 32'h77, 32'h77);
    drain(0);

    // Reset in the middle of SHIFT (cnt=3)
    do_accept(0, 32'hF0, 32'h0F);
    check("rst_clear_pulse", cmp_clr_a[0], 1);
    for (int i = 0; i < 4; i++) step();
    check("rst_pre_busy", busy_a[0], 1);
    rst = 1'b0;
    void'(exp_q.pop_front());
    #1;
    check_idle(0, "mid_reset");
    check("mid_reset_out", {out_g_a[0], out_e_a[0]}, 0);
    last_g[0] = 1'b0;
    last_e[0] = 1'b0;
    step();
    step();
    check("mid_reset_hold_out_valid", out_valid_a[0], 0);
    rst = 1'b1;
    step();
    check_idle(0, "after_reset");
    run_op(0, 32'h2, 32'h1);
    check("after_reset_g", out_g_a[0], 1);

    // Random traffic at N=32 and N=1
    for (int n = 0; n < 500; n++) begin
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? rx : $urandom;
      if ($urandom_range(0, 3) == 0) ry = rx ^ (32'h1 << $urandom_range(0, 31));
      run_op(1, rx, ry);
    end
    for (int n = 0; n < 500; n++) begin
      rx = $urandom;
      ry = $urandom;
      run_op(2, rx, ry);
    end

    step();
    for (int k = 0; k < 3; k++)
      check("clr_pulses_vs_ops", 32'(clr_cnt[k]), 32'(ops_acc[k]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
